// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and region helper for the memory-copy DMA.
package mem_pkg;
    localparam int AW          = 14;
    localparam int DW          = 10;
    localparam int RAM_WORDS   = 8192;
    localparam int ROM_SEL_BIT = AW - 1;

    typedef enum logic [2:0] {IDLE, CHECK, RD, RWAIT, WR, FIN} dma_state_t;

    function automatic logic is_rom(input logic [AW-1:0] addr);
        return addr[ROM_SEL_BIT];
    endfunction
endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy bus initiator for the RAM/ROM memory port; defining MEM_DMA_FILL_EN
// adds a write-only fill mode (fill / fill_value ports).
module mem_copy_dma
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
`ifdef MEM_DMA_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_value,
`endif
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    dma_state_t    state_reg;
    logic [AW-1:0] src_reg;
    logic [AW-1:0] dst_reg;
    logic [AW-1:0] remain_reg;
    logic [AW:0]   dst_end;
`ifdef MEM_DMA_FILL_EN
    logic          fill_reg;
    logic [DW-1:0] fill_value_reg;
`endif

    // One extra bit so a range ending exactly at the top of RAM is not mistaken for wrap.
    assign dst_end = {1'b0, dst_reg} + {1'b0, remain_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            remain_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
`ifdef MEM_DMA_FILL_EN
            fill_reg       <= 1'b0;
            fill_value_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_reg    <= src_addr;
                        dst_reg    <= dst_addr;
                        remain_reg <= len;
                        busy       <= 1'b1;
                        state_reg  <= CHECK;
`ifdef MEM_DMA_FILL_EN
                        fill_reg       <= fill;
                        fill_value_reg <= fill_value;
`endif
                    end
                end
                CHECK: begin
                    if (is_rom(dst_reg) || dst_end > (AW+1)'(RAM_WORDS)) begin
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end else if (remain_reg == '0) begin
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end else begin
`ifdef MEM_DMA_FILL_EN
                        if (fill_reg) begin
                            mem_addr  <= dst_reg;
                            mem_wdata <= fill_value_reg;
                            mem_write <= 1'b1;
                            state_reg <= WR;
                        end else begin
                            mem_addr  <= src_reg;
                            mem_read  <= 1'b1;
                            state_reg <= RD;
                        end
`else
                        mem_addr  <= src_reg;
                        mem_read  <= 1'b1;
                        state_reg <= RD;
`endif
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    // ROM data is combinational, so it is already valid in the RD cycle.
                    if (is_rom(src_reg)) begin
                        mem_addr  <= dst_reg;
                        mem_wdata <= mem_rdata;
                        mem_write <= 1'b1;
                        state_reg <= WR;
                    end else begin
                        state_reg <= RWAIT;
                    end
                end
                RWAIT: begin
                    mem_addr  <= dst_reg;
                    mem_wdata <= mem_rdata;
                    mem_write <= 1'b1;
                    state_reg <= WR;
                end
                WR: begin
                    src_reg    <= src_reg + AW'(1);
                    dst_reg    <= dst_reg + AW'(1);
                    remain_reg <= remain_reg - AW'(1);
                    if (remain_reg == AW'(1)) begin
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end else begin
`ifdef MEM_DMA_FILL_EN
                        if (fill_reg) begin
                            mem_addr  <= dst_reg + AW'(1);
                            mem_wdata <= fill_value_reg;
                        end else begin
                            mem_write <= 1'b0;
                            mem_addr  <= src_reg + AW'(1);
                            mem_read  <= 1'b1;
                            state_reg <= RD;
                        end
`else
                        mem_write <= 1'b0;
                        mem_addr  <= src_reg + AW'(1);
                        mem_read  <= 1'b1;
                        state_reg <= RD;
`endif
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized bench for mem_copy_dma with a RAM/ROM memory model and a word-level
// reference copy model; fill-mode cases compile in only with MEM_DMA_FILL_EN.
module tb_mem_copy_dma;
    import mem_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] len = '0;
`ifdef MEM_DMA_FILL_EN
    logic          fill = 1'b0;
    logic [DW-1:0] fill_value = '0;
`endif
    logic          busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ram     [RAM_WORDS];
    logic [DW-1:0] rom     [RAM_WORDS];
    logic [DW-1:0] ram_ref [RAM_WORDS];
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    mem_copy_dma dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
`ifdef MEM_DMA_FILL_EN
        .fill       (fill),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    // Memory: registered RAM read, combinational ROM read, output mux on addr[13].
    always @(posedge clk) begin
        if (mem_write && !mem_addr[13]) ram[mem_addr[12:0]] <= mem_wdata;
        ram_q <= ram[mem_addr[12:0]];
    end
    assign mem_rdata = mem_addr[13] ? rom[mem_addr[12:0]] : ram_q;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ram(input string tag);
        int diffs = 0;
        for (int i = 0; i < RAM_WORDS; i++)
            if (ram[i] !== ram_ref[i]) diffs++;
        chk(tag, diffs, 0);
    endtask

    // One request; the model applies the copy word by word in ascending order and
    // sums the per-word costs (RAM 3, ROM 2, fill 1) plus CHECK and FIN.
    task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] n, input bit f,
                            input logic [DW-1:0] fv, input bit poke);
        int exp_lat, exp_rd, exp_wr, t, got_lat, rd_cnt, wr_cnt, both_cnt, busy_gap;
        bit exp_err, got_err;
        logic [AW-1:0] sa, da;
        exp_err = d[13] || (int'(d) + int'(n) > RAM_WORDS);
        exp_lat = 2; exp_rd = 0; exp_wr = 0;
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                sa = s + AW'(i);
                da = d + AW'(i);
                if (f) begin
                    ram_ref[da[12:0]] = fv;
                    exp_lat += 1;
                end else begin
                    ram_ref[da[12:0]] = sa[13] ? rom[sa[12:0]] : ram_ref[sa[12:0]];
                    exp_lat += sa[13] ? 2 : 3;
                    exp_rd++;
                end
                exp_wr++;
            end
        end
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
`ifdef MEM_DMA_FILL_EN
        fill = f; fill_value = fv;
`endif
        t = 0; got_lat = -1; got_err = 1'b0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; busy_gap = 0;
        while (got_lat < 0 && t < exp_lat + 20) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
            if (mem_read && mem_write) both_cnt++;
            if (!busy) busy_gap++;
            if (done) begin
                got_lat = t;
                got_err = err;
            end
            if (poke && t == 2 && got_lat < 0) begin
                src_addr = AW'($urandom); dst_addr = AW'($urandom);
                len = AW'($urandom_range(1, 9)); start = 1'b1;
            end
        end
        start = 1'b0;
        chk("latency", got_lat, exp_lat);
        chk("err", int'(got_err), int'(exp_err));
        chk("reads", rd_cnt, exp_rd);
        chk("writes", wr_cnt, exp_wr);
        chk("rd_wr_overlap", both_cnt, 0);
        chk("busy_hold", busy_gap, 0);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("busy_release", int'(busy), 0);
        chk_ram("ram_contents");
        $display("xfer src=%04h dst=%04h len=%0d fill=%0d poke=%0d lat=%0d err=%0d",
                 s, d, n, f, poke, got_lat, got_err);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] s, d, n;
        logic [DW-1:0] v;
        for (int i = 0; i < RAM_WORDS; i++) begin
            v = DW'($urandom);
            ram[i] <= v;
            ram_ref[i] = v;
            rom[i] = (i < 4) ? DW'(i + 1) : DW'($urandom);
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_strobes", int'({mem_read, mem_write}), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(14'h2000, 14'h0010, 14'd4, 1'b0, '0, 1'b0);
        run_xfer(14'h0100, 14'h0200, 14'd3, 1'b0, '0, 1'b1);
        run_xfer(14'h0100, 14'h2005, 14'd2, 1'b0, '0, 1'b0);
        run_xfer(14'h0100, 14'h1FFF, 14'd2, 1'b0, '0, 1'b0);
        run_xfer(14'h0100, 14'h0300, 14'd0, 1'b0, '0, 1'b0);
        run_xfer(14'h1FFF, 14'h0400, 14'd2, 1'b0, '0, 1'b0);
        run_xfer(14'h3FFE, 14'h0500, 14'd3, 1'b0, '0, 1'b0);
        run_xfer(14'h0600, 14'h0602, 14'd5, 1'b0, '0, 1'b0);
        run_xfer(14'h2000, 14'h1FF0, 14'd16, 1'b0, '0, 1'b0);

        // Reset during RWAIT of the second of five RAM words.
        @(negedge clk);
        src_addr = 14'h0700; dst_addr = 14'h0800; len = 14'd5; start = 1'b1;
`ifdef MEM_DMA_FILL_EN
        fill = 1'b0;
`endif
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", int'({mem_read, mem_write}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        ram_ref[14'h0800] = ram_ref[14'h0700];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_idle", int'({busy, done}), 0);
        end
        chk_ram("abort_ram");
        $display("xfer aborted by reset src=0700 dst=0800 len=5");
        run_xfer(14'h0700, 14'h0800, 14'd5, 1'b0, '0, 1'b0);

`ifdef MEM_DMA_FILL_EN
        run_xfer(14'h0000, 14'h0000, 14'd8, 1'b1, 10'h3FF, 1'b0);
        run_xfer(14'h0000, 14'h2001, 14'd3, 1'b1, 10'h155, 1'b0);
`endif

        for (int k = 0; k < 30; k++) begin
            n = AW'($urandom_range(0, 12));
            s = AW'($urandom);
            if ($urandom_range(0, 3) == 0) d = AW'($urandom);
            else d = AW'($urandom_range(0, RAM_WORDS - int'(n)));
`ifdef MEM_DMA_FILL_EN
            run_xfer(s, d, n, bit'($urandom_range(0, 3) == 0), DW'($urandom),
                     bit'($urandom_range(0, 1)));
`else
            run_xfer(s, d, n, 1'b0, '0, bit'($urandom_range(0, 1)));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Bus initiator that drives the 14-bit-address / 10-bit-data memory port (RAM at addr[13]=0, ROM at addr[13]=1).
- Copies a block of `len` words from `src_addr` to `dst_addr`, e.g. ROM tables into RAM at boot, or RAM-to-RAM moves.
- Handles the differing read latency of the two regions: RAM read data is registered (1 cycle); ROM read data is combinational (same cycle).
- Sits between a control/sequencer block (start/busy/done handshake) and the memory port.

Parameters:
AW  14  memory address width; bit AW-1 selects ROM
DW  10  memory data width

Ports:
clk          in   1   system clock
rst_n        in   1   asynchronous active-low reset
start        in   1   request pulse; sampled only in IDLE
src_addr     in   AW  first source word address
dst_addr     in   AW  first destination word address
len          in   AW  word count, 0..8192
busy         out  1   high from accepted start until done cycle inclusive
done         out  1   one-cycle pulse at end of transfer or on rejection
err          out  1   one-cycle pulse with done when request rejected
mem_addr     out  AW  memory address
mem_wdata    out  DW  memory write data
mem_write    out  1   memory write strobe
mem_read     out  1   memory read strobe
mem_rdata    in   DW  memory read data

Behaviour:
- Interface fixed: one clock `clk`; reset `rst_n` asynchronous, active-low.
- Reset values: busy=0, done=0, err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, FSM=IDLE, counters=0.
- FSM states: IDLE, CHECK, RD, RWAIT, WR, FIN.
- IDLE:
  - start=1 latches src/dst/len, sets busy, goes to CHECK.
  - start while busy is ignored, never queued.
- CHECK (1 cycle, no memory strobes), checked in this order:
  - dst_addr[AW-1]=1, or dst_addr+len > 8192 (15-bit compare): reject, go to FIN with err=1.
  - Otherwise len=0: go to FIN with err=0.
  - Otherwise go to RD.
- RD: mem_addr=src, mem_read=1.
  - If src[AW-1]=1 (ROM): capture mem_rdata this cycle, go to WR.
  - Else (RAM): go to RWAIT.
- RWAIT: mem_addr held at src, mem_read=0; capture mem_rdata; go to WR.
  - src must stay in the RAM region during this cycle because the memory's output mux uses addr[13].
- WR: mem_addr=dst, mem_wdata=captured word, mem_write=1; then src+=1, dst+=1, remaining-=1.
  - If remaining becomes 0, go to FIN; else go to RD.
- FIN: done=1 for one cycle (err as decided in CHECK), busy=1; next cycle back to IDLE with busy=0.
  - Next start is accepted the cycle after FIN.
- Word cost: RAM source 3 cycles, ROM source 2 cycles.
  - Total latency (start to done) = 1 + sum(word costs) + 1.
- mem_read and mem_write are never asserted together. Both are 0 in IDLE, CHECK, RWAIT and FIN.
- Address increment wraps modulo 2^AW. A source range crossing 0x1FFF→0x2000 switches latency per word based on the current src[AW-1]. A source wrapping 0x3FFF→0x0000 is legal.
- Destination can never cross into ROM because CHECK rejects such requests.
- Overlapping src/dst ranges copy in ascending order; no overlap correction.
- rst_n asserted mid-transfer aborts immediately: strobes drop asynchronously, FSM goes to IDLE, no done pulse. Partially written RAM is left as is.

Optional Feature:
- Macro MEM_DMA_FILL_EN.
- Defined:
  - Extra ports `fill` (in, 1) and `fill_value` (in, DW), both latched with start.
  - When fill=1: RD and RWAIT are skipped. Each word is WR only, with mem_wdata=fill_value: 1 cycle/word, same CHECK rules.
- Undefined: ports absent; copy-only behaviour.

Decomposition:
- Package mem_pkg holds:
  - AW, DW, RAM_WORDS=8192, ROM_SEL_BIT=AW-1.
  - Enum type dma_state_t {IDLE, CHECK, RD, RWAIT, WR, FIN}.
  - Helper function `is_rom(addr)`.
- Single module; no sub-module. The counters and FSM are too tightly coupled to split usefully.

Test Plan:
- ROM→RAM copy:
  - Stimulus: src=0x2000, dst=0x0010, len=4, ROM preloaded 0x001..0x004.
  - Required: RAM[0x10..0x13]=0x001..0x004; done 10 cycles after start; no RWAIT states.
- RAM→RAM copy:
  - Stimulus: src=0x0100, dst=0x0200, len=3.
  - Required: data copied; 3 cycles/word; done at start+11; mem_read/mem_write never high together.
- Rejection:
  - Stimulus: dst=0x2005 (ROM), len=2.
  - Required: done+err pulse at start+2; zero memory strobes.
  - Stimulus: dst=0x1FFF, len=2.
  - Required: same rejection.
- Boundary:
  - Stimulus: len=0.
  - Required: done at start+2, err=0, no strobes.
  - Stimulus: src=0x1FFF, len=2.
  - Required: word 0 takes 3 cycles, word 1 (ROM 0x2000) takes 2 cycles.
- Reset and re-arm:
  - Stimulus: rst_n low during RWAIT of word 2 of 5.
  - Required: strobes 0 immediately, busy=0, no done; a new start after release runs correctly.
  - Stimulus: start asserted while busy.
  - Required: ignored.
- Fill mode (MEM_DMA_FILL_EN):
  - Stimulus: fill=1, fill_value=0x3FF, dst=0x0000, len=8.
  - Required: RAM[0..7]=0x3FF, 1 cycle/word, mem_read never asserted.
